// File: rtl/instruction_queue.sv
// Decoupling FIFO between fetch and decode: buffers {pc, instr} pairs in order
// and discards everything on a control-flow redirect (flush).
module instruction_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             push;
  logic             pop;

  // Readiness comes from occupancy alone, so a full queue never passes through.
  assign in_ready  = (occ != FULL_COUNT);
  assign out_valid = (occ != '0);
  assign count     = occ;
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occ <= occ + (PTR_W + 1)'(1);
      else if (pop && !push) occ <= occ - (PTR_W + 1)'(1);
    end
  end

  // Storage has no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed, table-driven bench for instruction_queue plus hand-written
// sequences for flush and asynchronous reset.
module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        ordy;
    logic [2:0]  exp_count;
    logic        exp_valid;
    logic        exp_in_ready;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  instruction_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'h2400_0000 | pc;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic fl,
                              input logic ordy, input int c, input logic v,
                              input logic ir, input logic [31:0] epc);
    vec_t r;
    r.iv = iv; r.pc = pc; r.ins = ins_of(pc); r.fl = fl; r.ordy = ordy;
    r.exp_count = 3'(c); r.exp_valid = v; r.exp_in_ready = ir;
    r.exp_pc = epc; r.exp_instr = ins_of(epc);
    return r;
  endfunction

  function automatic void add(input logic iv, input logic [31:0] pc, input logic ordy,
                              input int c, input logic v, input logic ir,
                              input logic [31:0] epc);
    vecs.push_back(mk(iv, pc, 1'b0, ordy, c, v, ir, epc));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_output(input vec_t v, input string tag);
    check({tag, ".count"}, 32'(count), 32'(v.exp_count));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v.exp_valid));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(v.exp_in_ready));
    if (v.exp_valid) begin
      check({tag, ".out_pc"}, out_pc, v.exp_pc);
      check({tag, ".out_instr"}, out_instr, v.exp_instr);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge happen, check at the next fall.
  task automatic apply_stimulus(input vec_t v, input string tag);
    in_valid  = v.iv;
    in_pc     = v.pc;
    in_instr  = v.ins;
    flush     = v.fl;
    out_ready = v.ordy;
    @(posedge clk);
    @(negedge clk);
    check_output(v, tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;

    // First push with the specific pair, then drain it.
    v = mk(1'b1, 32'h0000_3000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h0000_3000);
    v.ins = 32'h3c01_1234;
    v.exp_instr = 32'h3c01_1234;
    vecs.push_back(v);
    add(1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b1, 32'h0);

    // Fill to full; a fifth offer is refused; full+pop frees a slot but pushes nothing.
    add(1'b1, 32'h3000, 1'b0, 1, 1'b1, 1'b1, 32'h3000);
    add(1'b1, 32'h3004, 1'b0, 2, 1'b1, 1'b1, 32'h3000);
    add(1'b1, 32'h3008, 1'b0, 3, 1'b1, 1'b1, 32'h3000);
    add(1'b1, 32'h300c, 1'b0, 4, 1'b1, 1'b0, 32'h3000);
    add(1'b1, 32'h3010, 1'b0, 4, 1'b1, 1'b0, 32'h3000);
    add(1'b1, 32'h3010, 1'b1, 3, 1'b1, 1'b1, 32'h3004);
    add(1'b0, 32'h0,    1'b1, 2, 1'b1, 1'b1, 32'h3008);
    add(1'b0, 32'h0,    1'b1, 1, 1'b1, 1'b1, 32'h300c);
    add(1'b0, 32'h0,    1'b1, 0, 1'b0, 1'b1, 32'h0);

    // Steady streaming at occupancy 2 across pointer wrap.
    add(1'b1, 32'h3020, 1'b0, 1, 1'b1, 1'b1, 32'h3020);
    add(1'b1, 32'h3024, 1'b0, 2, 1'b1, 1'b1, 32'h3020);
    for (int i = 0; i < 6; i++)
      add(1'b1, 32'h3028 + 32'(4 * i), 1'b1, 2, 1'b1, 1'b1, 32'h3024 + 32'(4 * i));
    add(1'b0, 32'h0, 1'b1, 1, 1'b1, 1'b1, 32'h303c);
    add(1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b1, 32'h0);

    // Empty with out_ready high: no underflow; then a push shows one cycle later.
    for (int i = 0; i < 3; i++)
      add(1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b1, 32'h0);
    add(1'b1, 32'h3004, 1'b1, 1, 1'b1, 1'b1, 32'h3004);

    // Push and pop together at occupancy 1: head moves onto the new entry.
    add(1'b1, 32'h3040, 1'b1, 1, 1'b1, 1'b1, 32'h3040);
    add(1'b0, 32'h0,    1'b1, 0, 1'b0, 1'b1, 32'h0);

    // Reset state, checked while reset is held.
    #3;
    check("reset.count", 32'(count), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) apply_stimulus(vecs[i], $sformatf("v%0d", i));

    // Flush at occupancy 3 with a simultaneous push and pop.
    apply_stimulus(mk(1'b1, 32'h3050, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h3050), "fl.p0");
    apply_stimulus(mk(1'b1, 32'h3054, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h3050), "fl.p1");
    apply_stimulus(mk(1'b1, 32'h3058, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h3050), "fl.p2");
    apply_stimulus(mk(1'b1, 32'h3100, 1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h0), "fl.flush");
    apply_stimulus(mk(1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h0), "fl.idle");
    apply_stimulus(mk(1'b1, 32'h3104, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h3104), "fl.push");
    apply_stimulus(mk(1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h0), "fl.pop");

    // Asynchronous reset between edges at occupancy 3.
    apply_stimulus(mk(1'b1, 32'h3060, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h3060), "rs.p0");
    apply_stimulus(mk(1'b1, 32'h3064, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h3060), "rs.p1");
    apply_stimulus(mk(1'b1, 32'h3068, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h3060), "rs.p2");
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rs.async.count", 32'(count), 32'd0);
    check("rs.async.out_valid", 32'(out_valid), 32'd0);
    check("rs.async.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(mk(1'b1, 32'h3000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h3000), "rs.push");
    apply_stimulus(mk(1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h0), "rs.pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
